biriscv_div_issue_ctrl: RTL and testbench
=========================================

Name: biriscv_div_issue_ctrl

Overview:
- Sequencing stage wrapped around biriscv_divider.
- Upstream, it accepts one DIV/DIVU/REM/REMU op from the issue stage and launches it into the divider.
- It exposes busy and destination-register information to the scoreboard.
- Downstream, it captures the divider's one-cycle result pulse, tags it with rd/pc, and holds it on a ready/valid writeback port until the writeback mux takes it. Pipeline flushes discard in-flight results.

Parameters:
TIMEOUT, 64, max cycles in BUSY/DRAIN without a divider result before error abort; counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
issue_valid_i  in  1  issue stage presents an op
issue_opcode_i  in  32  instruction word
issue_pc_i  in  32  instruction pc
issue_rd_idx_i  in  5  destination register
issue_ra_operand_i  in  32  rs1 value
issue_rb_operand_i  in  32  rs2 value
issue_ready_o  out  1  controller can accept (combinational from state)
flush_i  in  1  squash in-flight div op
div_opcode_valid_o  out  1  start pulse to divider
div_opcode_o  out  32  opcode to divider
div_ra_operand_o  out  32  rs1 to divider
div_rb_operand_o  out  32  rs2 to divider
div_wb_valid_i  in  1  divider result pulse
div_wb_value_i  in  32  divider result
busy_o  out  1  op in flight (BUSY, DRAIN or HOLD)
busy_rd_idx_o  out  5  rd of live op; 0 when not live
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback mux accepts result
wb_rd_idx_o  out  5  result destination
wb_pc_o  out  32  result pc
wb_value_o  out  32  result value
err_o  out  1  sticky: timeout or unexpected divider pulse

Behaviour:
- One clock, clk. Synchronous active-high reset rst. All state is updated on the rising edge of clk only.
- Reset values:
  - state = IDLE.
  - All outputs = 0, except issue_ready_o = 1.
  - err_o is cleared only by rst.
- Decode: is_div = issue_opcode_i[6:0]==7'b0110011 && [31:25]==7'b0000001 && [14]==1.
  - A non-div op with issue_valid_i is ignored: no handshake and no state change.
- Accept: issue_valid_i & issue_ready_o & is_div & !flush_i.
  - On accept, register opcode, operands, rd and pc, and go to BUSY.
  - div_opcode_valid_o is high for exactly the one cycle after accept.
  - div_opcode_o and the operand outputs hold their captured values until the next accept.
- issue_ready_o = (state==IDLE).
- busy_o = (state != IDLE).
- busy_rd_idx_o = captured rd in BUSY/HOLD; 0 in IDLE/DRAIN.
- IDLE:
  - On accept, go to BUSY.
  - A div_wb_valid_i pulse in IDLE sets err_o and is otherwise ignored.
- BUSY:
  - The timeout counter is cleared on entry and increments each cycle.
  - On flush_i, go to DRAIN. The divider cannot be stopped, so its result must be consumed.
  - On div_wb_valid_i with no flush: capture div_wb_value_i.
    - If rd==0, go to IDLE with no writeback.
    - Otherwise go to HOLD.
  - If flush_i and div_wb_valid_i arrive in the same cycle, flush wins: the result is discarded and the next state is IDLE.
  - If the counter reaches TIMEOUT, set err_o and go to IDLE.
- DRAIN:
  - Wait for div_wb_valid_i, discard it, then go to IDLE.
  - The timeout counter continues from BUSY. On TIMEOUT, set err_o and go to IDLE.
  - flush_i is a no-op.
- HOLD:
  - wb_valid_o = 1. wb_rd_idx_o, wb_pc_o and wb_value_o are stable while wb_valid_o & !wb_ready_i.
  - On wb_ready_i, go to IDLE. Transfer happens on the edge where both valid and ready are high.
  - On flush_i, drop the result (wb_valid_o falls next cycle) and go to IDLE. A flush coinciding with wb_ready_i counts as a completed transfer.
  - A div_wb_valid_i pulse in HOLD sets err_o and is otherwise ignored.
- wb_* outputs are registered and driven only in HOLD; they read 0 otherwise.
- Minimum op-to-result latency:
  - accept → start pulse: 1 cycle.
  - start → divider result: variable; 2 cycles on the divider's repeated-operand fast path, about 34 otherwise.
  - result → wb_valid_o: 1 cycle.
- rst mid-operation returns to IDLE on the next edge. A divider pulse arriving afterwards sets err_o; the bench must reset the divider together with this block.

Test Plan:
- DIV 100/7, rd=5, pc=0x80 → one start pulse. About 36 cycles later wb_valid_o=1, wb_value_o=14, wb_rd_idx_o=5, wb_pc_o=0x80. wb_ready_i=1 → IDLE next cycle.
- REM ra=0xFFFFFFF9 (-7), rb=2, rd=3 → wb_value_o=0xFFFFFFFF. Then an identical REM again → fast-path result arrives 2 cycles after the start pulse with the same value.
- DIVU 0x10/0, wb_ready_i held 0 for 10 cycles → wb_valid_o stays 1 with value 0xFFFFFFFF stable. busy_o=1 and issue_ready_o=0 throughout. Release ready → single transfer.
- flush_i 5 cycles after accept → DRAIN, busy_rd_idx_o=0. The divider pulse is swallowed and wb_valid_o is never asserted. issue_ready_o returns 1 the cycle after the pulse.
- DIV with rd=0 → no wb_valid_o; IDLE the cycle after the divider pulse.
- Divider stub never responds, TIMEOUT=64 → err_o=1 at cycle 64 of BUSY, state IDLE. Inject a spurious div_wb_valid_i in IDLE → err_o stays 1 until rst.

Source files
------------

// File: rtl/biriscv_div_issue_ctrl_if.sv
// Bundle of the div issue controller's issue, divider and writeback signals.
//   slave  : the controller (takes issue/divider-result/writeback-ready, drives the rest)
//   master : the surrounding pipeline, divider and writeback mux
interface biriscv_div_issue_ctrl_if;
  // Issue stage
  logic        issue_valid_i;
  logic [31:0] issue_opcode_i;
  logic [31:0] issue_pc_i;
  logic [4:0]  issue_rd_idx_i;
  logic [31:0] issue_ra_operand_i;
  logic [31:0] issue_rb_operand_i;
  logic        issue_ready_o;
  logic        flush_i;
  // Divider launch / result
  logic        div_opcode_valid_o;
  logic [31:0] div_opcode_o;
  logic [31:0] div_ra_operand_o;
  logic [31:0] div_rb_operand_o;
  logic        div_wb_valid_i;
  logic [31:0] div_wb_value_i;
  // Scoreboard
  logic        busy_o;
  logic [4:0]  busy_rd_idx_o;
  // Writeback
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_value_o;
  logic        err_o;

  modport slave (
    input  issue_valid_i, issue_opcode_i, issue_pc_i, issue_rd_idx_i,
           issue_ra_operand_i, issue_rb_operand_i, flush_i,
           div_wb_valid_i, div_wb_value_i, wb_ready_i,
    output issue_ready_o, div_opcode_valid_o, div_opcode_o,
           div_ra_operand_o, div_rb_operand_o, busy_o, busy_rd_idx_o,
           wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o, err_o
  );

  modport master (
    output issue_valid_i, issue_opcode_i, issue_pc_i, issue_rd_idx_i,
           issue_ra_operand_i, issue_rb_operand_i, flush_i,
           div_wb_valid_i, div_wb_value_i, wb_ready_i,
    input  issue_ready_o, div_opcode_valid_o, div_opcode_o,
           div_ra_operand_o, div_rb_operand_o, busy_o, busy_rd_idx_o,
           wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o, err_o
  );
endinterface

// File: rtl/biriscv_div_issue_ctrl.sv
// Sequencing stage around biriscv_divider: accepts one DIV/DIVU/REM/REMU op,
// launches it, tracks it for the scoreboard and holds the tagged result on a
// ready/valid writeback port. Flushes discard in-flight results.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : issue / divider / scoreboard / writeback signals (slave side)
// Parameter:
//   TIMEOUT : cycles in BUSY/DRAIN without a divider result before error abort
module biriscv_div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  biriscv_div_issue_ctrl_if.slave    bus
);

  localparam int unsigned   CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      op_q, op_d;
  logic [31:0]      ra_q, ra_d;
  logic [31:0]      rb_q, rb_d;
  logic [31:0]      pc_q, pc_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      val_q, val_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             is_div;
  logic             accept;

  // RV32M divide/remainder group: OP major opcode, MULDIV funct7, funct3[2] set
  assign is_div = (bus.issue_opcode_i[6:0] == 7'b0110011) &&
                  (bus.issue_opcode_i[31:25] == 7'b0000001) &&
                  bus.issue_opcode_i[14];

  assign accept = (state_q == IDLE) && bus.issue_valid_i && is_div && !bus.flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      val_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    val_d   = val_q;
    start_d = 1'b0;
    err_d   = err_q;
    // Saturates so a flush landing on the timeout cycle still aborts in DRAIN
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.div_wb_valid_i) err_d = 1'b1;
        if (accept) begin
          op_d    = bus.issue_opcode_i;
          ra_d    = bus.issue_ra_operand_i;
          rb_d    = bus.issue_rb_operand_i;
          pc_d    = bus.issue_pc_i;
          rd_d    = bus.issue_rd_idx_i;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (bus.flush_i) begin
          // A result arriving with the flush is already consumed
          state_d = bus.div_wb_valid_i ? IDLE : DRAIN;
        end else if (bus.div_wb_valid_i) begin
          val_d   = bus.div_wb_value_i;
          state_d = (rd_q == 5'd0) ? IDLE : HOLD;
        end else if (cnt_inc == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (bus.div_wb_valid_i) begin
          state_d = IDLE;
        end else if (cnt_inc == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.div_wb_valid_i) err_d = 1'b1;
        if (bus.wb_ready_i || bus.flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.issue_ready_o      = (state_q == IDLE);
  assign bus.busy_o             = (state_q != IDLE);
  assign bus.busy_rd_idx_o      = ((state_q == BUSY) || (state_q == HOLD)) ? rd_q : 5'd0;
  assign bus.div_opcode_valid_o = start_q;
  assign bus.div_opcode_o       = op_q;
  assign bus.div_ra_operand_o   = ra_q;
  assign bus.div_rb_operand_o   = rb_q;
  assign bus.wb_valid_o         = (state_q == HOLD);
  assign bus.wb_rd_idx_o        = (state_q == HOLD) ? rd_q  : 5'd0;
  assign bus.wb_pc_o            = (state_q == HOLD) ? pc_q  : 32'd0;
  assign bus.wb_value_o         = (state_q == HOLD) ? val_q : 32'd0;
  assign bus.err_o              = err_q;

endmodule

// File: tb/tb_biriscv_div_issue_ctrl.sv
// Bench for biriscv_div_issue_ctrl: divider stub, behavioural model, per-cycle
// compare plus directed literal checks and a randomized phase.
module tb_biriscv_div_issue_ctrl;
  localparam int unsigned TIMEOUT = 64;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  biriscv_div_issue_ctrl_if bus();

  biriscv_div_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_op(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd5, opc};
  endfunction

  function automatic bit m_is_div(logic [31:0] op);
    return (op & 32'hFE00_407F) == 32'h0200_4033;
  endfunction

  function automatic logic [31:0] ref_div(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'b100:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return 32'(sa / sb);
      3'b101:  if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'b110:  if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- divider stub ----------------
  bit         stub_mute = 0;
  bit         stub_rand = 0;
  int         spur_cnt  = 0;

  initial begin : stub
    int          s_rem;
    int          spur_seen;
    logic [66:0] s_last, key;
    bit          s_last_ok, fast;
    logic [31:0] s_res;
    s_rem = 0; spur_seen = 0; s_last = '0; s_last_ok = 0; s_res = '0;
    bus.div_wb_valid_i <= 1'b0;
    bus.div_wb_value_i <= 32'd0;
    forever begin
      @(posedge clk);
      bus.div_wb_valid_i <= 1'b0;
      if (rst) begin
        s_rem = 0;
        s_last_ok = 0;
        spur_seen = spur_cnt;
      end else begin
        if (spur_seen != spur_cnt) begin
          spur_seen = spur_cnt;
          bus.div_wb_valid_i <= 1'b1;
          bus.div_wb_value_i <= 32'hDEAD_BEEF;
        end
        if (bus.div_opcode_valid_o && !stub_mute) begin
          key       = {bus.div_opcode_o[14:12], bus.div_ra_operand_o, bus.div_rb_operand_o};
          fast      = s_last_ok && (key == s_last);
          s_last    = key;
          s_last_ok = 1;
          s_res     = ref_div(bus.div_opcode_o[14:12], bus.div_ra_operand_o, bus.div_rb_operand_o);
          s_rem     = fast ? 2 : (stub_rand ? int'($urandom_range(3, 12)) : 34);
        end
        if (s_rem > 0) begin
          s_rem--;
          if (s_rem == 0) begin
            bus.div_wb_valid_i <= 1'b1;
            bus.div_wb_value_i <= s_res;
          end
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Op life cycle as flags: computing (result wanted), squashed (result to drop),
  // holding (result offered to writeback). None set means free.
  bit          m_ok = 0;
  bit          m_comp, m_squash, m_hold, m_start, m_err;
  int          m_age;
  logic [31:0] m_op, m_ra, m_rb, m_pc, m_val;
  logic [4:0]  m_rd;

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ok = 1; m_comp = 0; m_squash = 0; m_hold = 0; m_start = 0; m_err = 0;
        m_age = 0; m_op = 0; m_ra = 0; m_rb = 0; m_pc = 0; m_val = 0; m_rd = 0;
      end else if (m_ok) begin
        m_start = 0;
        if (!(m_comp || m_squash || m_hold)) begin
          if (bus.div_wb_valid_i) m_err = 1;
          if (bus.issue_valid_i && m_is_div(bus.issue_opcode_i) && !bus.flush_i) begin
            m_op = bus.issue_opcode_i; m_ra = bus.issue_ra_operand_i;
            m_rb = bus.issue_rb_operand_i; m_pc = bus.issue_pc_i;
            m_rd = bus.issue_rd_idx_i; m_comp = 1; m_age = 0; m_start = 1;
          end
        end else if (m_comp) begin
          m_age++;
          m_comp = 0;
          if (bus.flush_i)             m_squash = !bus.div_wb_valid_i;
          else if (bus.div_wb_valid_i) begin m_val = bus.div_wb_value_i; m_hold = (m_rd != 0); end
          else if (m_age >= TIMEOUT)   m_err = 1;
          else                         m_comp = 1;
        end else if (m_squash) begin
          m_age++;
          if (bus.div_wb_valid_i)    m_squash = 0;
          else if (m_age >= TIMEOUT) begin m_squash = 0; m_err = 1; end
        end else begin
          if (bus.div_wb_valid_i) m_err = 1;
          if (bus.wb_ready_i || bus.flush_i) m_hold = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int wbv_cnt  = 0;
  int xfer_cnt = 0;

  initial begin : compare
    bit idle;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        idle = !(m_comp || m_squash || m_hold);
        cmp("issue_ready", 32'(bus.issue_ready_o), 32'(idle));
        cmp("busy",        32'(bus.busy_o), 32'(!idle));
        cmp("busy_rd",     32'(bus.busy_rd_idx_o), (m_comp || m_hold) ? 32'(m_rd) : 32'd0);
        cmp("start",       32'(bus.div_opcode_valid_o), 32'(m_start));
        cmp("div_opcode",  bus.div_opcode_o, m_op);
        cmp("div_ra",      bus.div_ra_operand_o, m_ra);
        cmp("div_rb",      bus.div_rb_operand_o, m_rb);
        cmp("wb_valid",    32'(bus.wb_valid_o), 32'(m_hold));
        cmp("wb_rd",       32'(bus.wb_rd_idx_o), m_hold ? 32'(m_rd) : 32'd0);
        cmp("wb_pc",       bus.wb_pc_o, m_hold ? m_pc : 32'd0);
        cmp("wb_value",    bus.wb_value_o, m_hold ? m_val : 32'd0);
        cmp("err",         32'(bus.err_o), 32'(m_err));
      end
      if (bus.wb_valid_o) wbv_cnt++;
      if (bus.wb_valid_o && bus.wb_ready_i) xfer_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!bus.issue_ready_o && k < budget) begin step(); k++; end
    cmp("wait_ready", 32'(bus.issue_ready_o), 32'd1);
  endtask

  task automatic issue(input logic [31:0] op, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [4:0] rd, input logic [31:0] pc);
    wait_ready(200);
    bus.issue_valid_i      = 1'b1;
    bus.issue_opcode_i     = op;
    bus.issue_ra_operand_i = ra;
    bus.issue_rb_operand_i = rb;
    bus.issue_rd_idx_i     = rd;
    bus.issue_pc_i         = pc;
    step();
    bus.issue_valid_i      = 1'b0;
  endtask

  // Cycles counted from the accept edge until wb_valid_o is seen
  task automatic wait_wb(output int n);
    n = 1;
    while (!bus.wb_valid_o && n < 200) begin step(); n++; end
    cmp("wb_arrive", 32'(bus.wb_valid_o), 32'd1);
  endtask

  task automatic take_wb();
    bus.wb_ready_i = 1'b1;
    step();
    bus.wb_ready_i = 1'b0;
  endtask

  localparam logic [6:0] F7_MD = 7'b0000001;
  localparam logic [6:0] OPC_OP = 7'b0110011;

  initial begin : stim
    int          n, w0, x0;
    logic [31:0] op_div, op_divu, op_rem, r_op, r_ra, r_rb;
    op_div  = mk_op(F7_MD, 3'b100, OPC_OP);
    op_divu = mk_op(F7_MD, 3'b101, OPC_OP);
    op_rem  = mk_op(F7_MD, 3'b110, OPC_OP);

    rst = 1'b1;
    bus.issue_valid_i = 0; bus.issue_opcode_i = 0; bus.issue_pc_i = 0;
    bus.issue_rd_idx_i = 0; bus.issue_ra_operand_i = 0; bus.issue_rb_operand_i = 0;
    bus.flush_i = 0; bus.wb_ready_i = 0;
    repeat (3) step();
    rst = 1'b0;
    cmp("rst_ready", 32'(bus.issue_ready_o), 32'd1);
    cmp("rst_busy",  32'(bus.busy_o), 32'd0);
    cmp("rst_wbv",   32'(bus.wb_valid_o), 32'd0);
    cmp("rst_err",   32'(bus.err_o), 32'd0);

    // DIV 100/7
    issue(op_div, 32'd100, 32'd7, 5'd5, 32'h80);
    wait_wb(n);
    cmp("div_latency", 32'(n), 32'd36);
    cmp("div_value", bus.wb_value_o, 32'd14);
    cmp("div_rd",    32'(bus.wb_rd_idx_o), 32'd5);
    cmp("div_pc",    bus.wb_pc_o, 32'h80);
    take_wb();
    cmp("div_idle",  32'(bus.issue_ready_o), 32'd1);

    // REM -7 % 2, then identical op on the fast path
    issue(op_rem, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h84);
    wait_wb(n);
    cmp("rem_value", bus.wb_value_o, 32'hFFFF_FFFF);
    take_wb();
    issue(op_rem, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h88);
    wait_wb(n);
    cmp("rem_fast_latency", 32'(n), 32'd4);
    cmp("rem_fast_value", bus.wb_value_o, 32'hFFFF_FFFF);
    take_wb();

    // DIVU by zero with writeback back-pressure
    issue(op_divu, 32'h10, 32'd0, 5'd7, 32'h100);
    wait_wb(n);
    x0 = xfer_cnt;
    repeat (10) begin
      cmp("bp_valid", 32'(bus.wb_valid_o), 32'd1);
      cmp("bp_value", bus.wb_value_o, 32'hFFFF_FFFF);
      cmp("bp_ready", 32'(bus.issue_ready_o), 32'd0);
      step();
    end
    take_wb();
    cmp("bp_released", 32'(bus.wb_valid_o), 32'd0);
    step();
    cmp("bp_one_xfer", 32'(xfer_cnt - x0), 32'd1);

    // Flush 5 cycles after accept: result drained, never written back
    w0 = wbv_cnt;
    issue(op_div, 32'd1000, 32'd3, 5'd9, 32'h200);
    repeat (4) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    cmp("drain_busy",   32'(bus.busy_o), 32'd1);
    cmp("drain_rd",     32'(bus.busy_rd_idx_o), 32'd0);
    wait_ready(100);
    cmp("drain_no_wb",  32'(wbv_cnt - w0), 32'd0);

    // rd == 0 retires silently
    w0 = wbv_cnt;
    issue(op_div, 32'd50, 32'd5, 5'd0, 32'h300);
    wait_ready(100);
    cmp("rd0_no_wb", 32'(wbv_cnt - w0), 32'd0);

    // Non-div ops are ignored
    bus.issue_valid_i  = 1'b1;
    bus.issue_opcode_i = mk_op(F7_MD, 3'b000, OPC_OP);
    step();
    bus.issue_opcode_i = mk_op(7'b0000000, 3'b100, OPC_OP);
    step();
    bus.issue_valid_i  = 1'b0;
    cmp("nondiv_busy",  32'(bus.busy_o), 32'd0);
    cmp("nondiv_start", 32'(bus.div_opcode_valid_o), 32'd0);

    // Randomized phase
    stub_rand = 1;
    r_op = op_div; r_ra = 32'd1; r_rb = 32'd1;
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.issue_valid_i = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) < 3) begin
          // reuse previous op/operands to hit the fast path
        end else if ($urandom_range(0, 9) < 8) begin
          r_op = mk_op(F7_MD, 3'(4 + $urandom_range(0, 3)), OPC_OP);
          r_ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
          r_rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(1, 1000));
        end else begin
          r_op = ($urandom_range(0, 1) == 0) ? mk_op(F7_MD, 3'b001, OPC_OP)
                                             : mk_op(F7_MD, 3'b100, 7'b0010011);
        end
        bus.issue_valid_i      = 1'b1;
        bus.issue_opcode_i     = r_op;
        bus.issue_ra_operand_i = r_ra;
        bus.issue_rb_operand_i = r_rb;
        bus.issue_rd_idx_i     = 5'($urandom_range(0, 31));
        bus.issue_pc_i         = {$urandom_range(0, 65535), 2'b00};
      end
      bus.flush_i    = ($urandom_range(0, 24) == 0);
      bus.wb_ready_i = ($urandom_range(0, 1) == 1);
    end
    bus.issue_valid_i = 1'b0;
    bus.flush_i       = 1'b0;
    bus.wb_ready_i    = 1'b1;
    wait_ready(100);
    bus.wb_ready_i    = 1'b0;
    stub_rand = 0;
    cmp("rand_no_err", 32'(bus.err_o), 32'd0);

    // Reset mid-operation, divider reset alongside
    issue(op_divu, 32'd77, 32'd5, 5'd4, 32'h400);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp("midrst_ready", 32'(bus.issue_ready_o), 32'd1);
    repeat (40) step();
    cmp("midrst_err",   32'(bus.err_o), 32'd0);

    // Timeout with a silent divider, then a spurious pulse in IDLE
    stub_mute = 1;
    issue(op_div, 32'd9, 32'd3, 5'd6, 32'h500);
    repeat (63) step();
    cmp("to_err_before", 32'(bus.err_o), 32'd0);
    cmp("to_busy",       32'(bus.busy_o), 32'd1);
    step();
    cmp("to_err",        32'(bus.err_o), 32'd1);
    cmp("to_idle",       32'(bus.issue_ready_o), 32'd1);
    spur_cnt++;
    repeat (3) step();
    cmp("spur_err_sticky", 32'(bus.err_o), 32'd1);
    stub_mute = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp("err_cleared", 32'(bus.err_o), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
